// File: rtl/mil_transmitter_pkg.sv
// ---------------------------------------------------------------------------
// milStd1553 : shared types for the MIL-STD-1553 word transmitter.
//   WordType   - word tag carried alongside each 16-bit word (WNULL = nothing)
//   MilData    - tagged word as held between accept and serialisation
//   tx_state_e - transmitter frame state
//   build_frame- expands a tagged word into its 40 half-bit Manchester frame,
//                first half-bit in bit 39
// ---------------------------------------------------------------------------
package milStd1553;

  typedef enum logic [1:0] {
    WNULL    = 2'd0,
    WCOMMAND = 2'd1,
    WSTATUS  = 2'd2,
    WDATA    = 2'd3
  } WordType;

  typedef struct packed {
    WordType     dataType;
    logic [15:0] content;
  } MilData;

  localparam int SYNC_HALF_BITS  = 6;
  localparam int FRAME_HALF_BITS = 40;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_PARITY
  } tx_state_e;

  // Command/status sync is high-then-low, data sync is low-then-high.
  // Each data/parity bit: 1 -> 10, 0 -> 01. Parity makes the ones count odd.
  function automatic logic [39:0] build_frame(input MilData w);
    logic [5:0]  sync;
    logic [31:0] body;
    logic [1:0]  par;
    sync = (w.dataType == WDATA) ? 6'b000111 : 6'b111000;
    body = '0;
    for (int i = 0; i < 16; i++) begin
      body = {body[29:0], (w.content[15-i] ? 2'b10 : 2'b01)};
    end
    par = (~^w.content) ? 2'b10 : 2'b01;
    return {sync, body, par};
  endfunction

endpackage

// File: rtl/mil_io_tick.sv
// ---------------------------------------------------------------------------
// mil_io_tick : brings the asynchronous ioClk level into the clk domain and
// turns each rising edge into a single-cycle tick (one half-bit time).
// tick is registered, so it appears 3 clk after ioClk rises.
// Ports:
//   clk    in  system clock
//   rst    in  synchronous active-low reset
//   io_clk in  asynchronous bit-timing strobe
//   tick   out one-clk pulse per io_clk rising edge
// ---------------------------------------------------------------------------
module mil_io_tick (
  input  logic clk,
  input  logic rst,
  input  logic io_clk,
  output logic tick
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic tick_q,  tick_d;

  always_comb begin
    sync1_d = io_clk;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    tick_d  = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/mil_transmitter.sv
// ---------------------------------------------------------------------------
// mil_transmitter : MIL-STD-1553 word transmitter.
// Accepts tagged 16-bit words from a push producer into a one-word holding
// register, and serialises each as a 40 half-bit Manchester II frame
// (sync, 16 data bits MSB first, odd parity). The holding register reloads
// the shifter on the last tick of a frame so frames run back-to-back.
// Optional feature: define MIL_TX_DIFF_EN to add the complementary line_n.
// Ports:
//   clk, rst       system clock, synchronous active-low reset
//   ioClk          asynchronous half-bit strobe
//   enable         low forces the transmitter idle and drops any held word
//   push_request   producer has a word; push_type / push_data describe it
//   push_done      one-clk pulse, word accepted
//   line           Manchester output, idles low
//   busy           a word is held or being shifted
//   line_n         (MIL_TX_DIFF_EN only) complement of line while framing
// ---------------------------------------------------------------------------
module mil_transmitter
  import milStd1553::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ioClk,
  input  logic        enable,
  input  logic        push_request,
  input  logic [1:0]  push_type,
  input  logic [15:0] push_data,
  output logic        push_done,
  output logic        line,
`ifdef MIL_TX_DIFF_EN
  output logic        line_n,
`endif
  output logic        busy
);

  localparam logic [5:0] SYNC_LAST  = 6'(SYNC_HALF_BITS - 1);
  localparam logic [5:0] DATA_LAST  = 6'(SYNC_HALF_BITS + 32 - 1);
  localparam logic [5:0] FRAME_LAST = 6'(FRAME_HALF_BITS - 1);

  logic tick;

  mil_io_tick u_io_tick (
    .clk    (clk),
    .rst    (rst),
    .io_clk (ioClk),
    .tick   (tick)
  );

  tx_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [39:0] shift_q, shift_d;
  MilData      hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        line_q, line_d;
  logic        push_done_q, push_done_d;

  logic accept;
  logic frame_end;
  logic load;

  // push_done_q blocks a second accept while the producer is still
  // dropping its request after seeing the pulse.
  assign accept    = enable & push_request & (push_type != WNULL) &
                     ~hold_full_q & ~push_done_q;
  assign frame_end = tick & (state_q == S_PARITY) & (cnt_q == FRAME_LAST);
  assign load      = hold_full_q & ((state_q == S_IDLE) | frame_end);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    line_d      = line_q;
    push_done_d = 1'b0;

    if (!enable) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      hold_full_d = 1'b0;
      line_d      = 1'b0;
    end else begin
      if (tick) begin
        if (state_q == S_IDLE) begin
          // The last half-bit of a frame is held for a full half-bit, then
          // the first idle tick returns the line low.
          line_d = 1'b0;
        end else begin
          line_d  = shift_q[39];
          shift_d = {shift_q[38:0], 1'b0};
          cnt_d   = cnt_q + 6'd1;
          case (state_q)
            S_SYNC:   if (cnt_q == SYNC_LAST) state_d = S_DATA;
            S_DATA:   if (cnt_q == DATA_LAST) state_d = S_PARITY;
            S_PARITY: begin
              if (cnt_q == FRAME_LAST) begin
                state_d = S_IDLE;
                cnt_d   = '0;
              end
            end
            default: ;
          endcase
        end
      end

      // A reload on the final tick overrides the return to idle, so the
      // next sync half-bit goes out on the very next tick.
      if (load) begin
        shift_d     = build_frame(hold_q);
        cnt_d       = '0;
        state_d     = S_SYNC;
        hold_full_d = 1'b0;
      end

      if (accept) begin
        hold_d.dataType = WordType'(push_type);
        hold_d.content  = push_data;
        hold_full_d     = 1'b1;
        push_done_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
      line_q      <= 1'b0;
      push_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
      line_q      <= line_d;
      push_done_q <= push_done_d;
    end
  end

  // Word content carries no control meaning, so it is left unreset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    hold_q  <= hold_d;
  end

  assign line      = line_q;
  assign push_done = push_done_q;
  assign busy      = (state_q != S_IDLE) | hold_full_q;

`ifdef MIL_TX_DIFF_EN
  logic line_n_q, line_n_d;

  always_comb begin
    line_n_d = line_n_q;
    if (!enable) begin
      line_n_d = 1'b0;
    end else if (tick) begin
      line_n_d = (state_q == S_IDLE) ? 1'b0 : ~shift_q[39];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) line_n_q <= 1'b0;
    else      line_n_q <= line_n_d;
  end

  assign line_n = line_n_q;
`endif

endmodule

// File: tb/tb_mil_transmitter.sv
// ---------------------------------------------------------------------------
// tb_mil_transmitter : scoreboard bench for mil_transmitter.
// The stimulus side pushes words; each accepted word becomes an expected
// frame (start half-bit period plus 40 half-bit values) in a queue. A
// monitor samples line in the middle of every half-bit period and compares
// against the head of the queue, or expects idle low between frames.
// ---------------------------------------------------------------------------
module tb_mil_transmitter;
  import milStd1553::*;

  localparam int P = 10;  // clk cycles per ioClk period (one half-bit)

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ioClk = 1'b0;
  logic        enable = 1'b0;
  logic        push_request = 1'b0;
  logic [1:0]  push_type = 2'd0;
  logic [15:0] push_data = 16'd0;
  logic        push_done;
  logic        line;
  logic        busy;
`ifdef MIL_TX_DIFF_EN
  logic        line_n;
`endif

  mil_transmitter dut (
    .clk          (clk),
    .rst          (rst),
    .ioClk        (ioClk),
    .enable       (enable),
    .push_request (push_request),
    .push_type    (push_type),
    .push_data    (push_data),
    .push_done    (push_done),
    .line         (line),
`ifdef MIL_TX_DIFF_EN
    .line_n       (line_n),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ioClk rises on the negedge where cyc is a multiple of P.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc % P == 0)      ioClk = 1'b1;
      else if (cyc % P == 5) ioClk = 1'b0;
    end
  end

  typedef struct {
    int          start;
    logic [39:0] bits;
  } frame_t;

  frame_t exp_q[$];
  int     vectors = 0;
  int     errors = 0;
  int     free_period = 0;
  bit     monitor_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference frame from the protocol rules: sync pattern by word type,
  // each bit as (bit, not bit), parity chosen to make the ones count odd.
  function automatic logic [39:0] model_frame(input logic [1:0] t, input logic [15:0] d);
    bit          hb[$];
    bit          par;
    logic [39:0] f;
    if (t == 2'd3) hb = '{0, 0, 0, 1, 1, 1};
    else           hb = '{1, 1, 1, 0, 0, 0};
    for (int i = 15; i >= 0; i--) begin
      hb.push_back(d[i]);
      hb.push_back(!d[i]);
    end
    par = ($countones(d) % 2 == 0);
    hb.push_back(par);
    hb.push_back(!par);
    for (int i = 0; i < 40; i++) f[39-i] = hb[i];
    return f;
  endfunction

  // Drive one word and wait for acceptance. A word accepted at edge E is
  // loaded one clk later; the first tick it can use lies in the first
  // ioClk period k with k*P + 2 >= E, unless a frame is still queued ahead.
  task automatic do_push(input logic [1:0] t, input logic [15:0] d, output int start);
    bit     ok;
    int     e;
    int     k0;
    frame_t fr;
    push_type    = t;
    push_data    = d;
    push_request = 1'b1;
    ok           = 1'b0;
    start        = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (push_done) begin
        ok = 1'b1;
        break;
      end
    end
    push_request = 1'b0;
    if (!ok) begin
      check("push_done_timeout", 32'd0, 32'd1);
    end else begin
      e     = cyc;
      k0    = (e - 2 + P - 1) / P;
      start = (k0 > free_period) ? k0 : free_period;
      free_period = start + 40;
      fr.start = start;
      fr.bits  = model_frame(t, d);
      exp_q.push_back(fr);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 8000 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 32'd0);
    repeat (3 * P) @(negedge clk);
  endtask

  // Line monitor: mid-half-bit sample of every ioClk period.
  initial begin
    int k;
    int idx;
    forever begin
      @(negedge clk);
      if (monitor_on && (cyc % P == 8)) begin
        k = cyc / P;
        if (exp_q.size() > 0 && k >= exp_q[0].start) begin
          idx = k - exp_q[0].start;
          check("line_halfbit", line, exp_q[0].bits[39-idx]);
`ifdef MIL_TX_DIFF_EN
          check("line_n_halfbit", line_n, ~exp_q[0].bits[39-idx]);
`endif
          if (idx < 39 || exp_q.size() > 1) check("busy_in_frame", busy, 1'b1);
          if (idx >= 39) void'(exp_q.pop_front());
        end else begin
          check("line_idle", line, 1'b0);
        end
      end
    end
  end

  // push_done must never be high on two consecutive cycles.
  initial begin
    bit pd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (push_done) check("push_done_single", pd_prev, 1'b0);
      pd_prev = push_done;
    end
  end

  initial begin
    int s;
    int pulses;
    bit reached;

    // Reset held low for two clocks.
    repeat (2) @(posedge clk);
    #1;
    check("reset_line", line, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_push_done", push_done, 1'b0);
    @(negedge clk);
    rst        = 1'b1;
    enable     = 1'b1;
    monitor_on = 1'b1;
    repeat (2 * P) @(negedge clk);

    // Single command word.
    do_push(2'd1, 16'h02A1, s);
    wait_idle();

    // Command then data back-to-back: second frame is contiguous.
    do_push(2'd1, 16'h02A1, s);
    do_push(2'd3, 16'h02A1, s);
    wait_idle();

    // Parity boundaries: even count of ones and a single one.
    do_push(2'd3, 16'hFFFF, s);
    do_push(2'd3, 16'h0001, s);
    do_push(2'd2, 16'h0000, s);
    wait_idle();

    // WNULL is never accepted.
    push_type    = 2'd0;
    push_data    = 16'hBEEF;
    push_request = 1'b1;
    pulses       = 0;
    repeat (50) begin
      @(negedge clk);
      if (push_done) pulses++;
    end
    push_request = 1'b0;
    check("wnull_push_done", pulses, 32'd0);
    check("wnull_busy", busy, 1'b0);

    // Randomised words with random gaps, sometimes back-to-back.
    for (int n = 0; n < 16; n++) begin
      do_push(2'($urandom_range(1, 3)), 16'($urandom), s);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 600)) @(negedge clk);
    end
    wait_idle();

    // Abort at half-bit 20 of a frame.
    do_push(2'd1, 16'($urandom), s);
    reached = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (cyc == (s + 20) * P + 6) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort_reached", reached, 1'b1);
    enable = 1'b0;
    exp_q.delete();
    free_period = 0;
    @(posedge clk);
    #1;
    check("abort_line", line, 1'b0);
    check("abort_busy", busy, 1'b0);

    // A request while disabled is not accepted.
    push_type    = 2'd2;
    push_data    = 16'h1234;
    push_request = 1'b1;
    pulses       = 0;
    repeat (40) begin
      @(negedge clk);
      if (push_done) pulses++;
    end
    check("disabled_push_done", pulses, 32'd0);
    check("disabled_busy", busy, 1'b0);
    enable = 1'b1;
    do_push(2'd2, 16'h1234, s);
    wait_idle();

    // A few more random words after re-enable.
    for (int n = 0; n < 4; n++) do_push(2'($urandom_range(1, 3)), 16'($urandom), s);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL global_timeout at cyc %0d: got no finish, expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
